// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the RV32I core. Issues in-order instruction memory requests and buffers
// returned words with their PC. Branch/jump redirects flush the buffer and drain stale responses.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc
);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [CW:0]     DEPTH_L = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, rsp_pc, target_pc;
    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] discard, discard_next;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic          req_valid, req_valid_next;
    logic          accept, rsp_live, push, pop;
    logic          unused_low_bits;

    assign target_pc       = {i_redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^i_redirect_pc[1:0];

    // A response with nothing outstanding is spurious and ignored entirely.
    assign accept   = req_valid & i_imem_req_ready;
    assign rsp_live = i_imem_rsp_valid & (outstanding != '0);
    assign push     = rsp_live & (state == FETCH) & (discard == '0) & ~i_redirect_valid;
    assign pop      = o_instr_valid & i_instr_ready & ~i_redirect_valid;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        state_next       = state;
        discard_next     = discard;
        outstanding_next = outstanding + CW'(accept) - CW'(rsp_live);
        count_next       = i_redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        if (i_redirect_valid) begin
            // Requests accepted this very cycle still belong to the old path.
            discard_next = outstanding_next;
            state_next   = (outstanding_next != '0) ? FLUSH : FETCH;
        end else if (state == FLUSH && rsp_live) begin
            discard_next = discard - ONE;
            if (discard == ONE) state_next = FETCH;
        end
        // Registered so the request side never sees a combinational path from inputs.
        req_valid_next = (state_next == FETCH) &&
                         (({1'b0, outstanding_next} + {1'b0, count_next}) < DEPTH_L);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            req_valid   <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            count       <= count_next;
            req_valid   <= req_valid_next;
            if (i_redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: buffer storage has no reset; count gates every read so stale contents are never visible.
    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= i_imem_rsp_data;
            pc_mem[wr_ptr]    <= rsp_pc;
        end
    end

    assign o_imem_req_valid = req_valid;
    assign o_imem_addr      = fetch_pc;
    assign o_instr_valid    = (count != '0);
    assign o_instruction    = o_instr_valid ? instr_mem[rd_ptr] : NOP;
    assign o_pc             = o_instr_valid ? pc_mem[rd_ptr] : 32'h0000_0000;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, stalls, redirects, wrap and async reset.
// A small in-order memory model answers accepted requests one cycle later unless held.
module tb_instruction_fetch_unit;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pend[$];
    logic [31:0] acc_log[$];
    logic        mem_en;
    logic        rsp_from_q;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h0031_00b3;
            32'h4: return 32'h0030_0093;
            32'h8: return 32'h0020_a023;
            default: return a ^ 32'h1234_0013;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_mem();
        rsp_from_q       = mem_en && (pend.size() > 0);
        i_imem_rsp_valid = rsp_from_q;
        i_imem_rsp_data  = rsp_from_q ? mem_word(pend[0]) : 32'h0;
    endtask

    // Samples handshakes before the edge, then updates the memory model 1 time unit after it.
    task automatic tick();
        logic        acc, taken;
        logic [31:0] a, dummy;
        acc   = o_imem_req_valid && i_imem_req_ready;
        a     = o_imem_addr;
        taken = rsp_from_q && i_imem_rsp_valid;
        @(posedge i_clk);
        if (taken) dummy = pend.pop_front();
        if (acc) begin
            pend.push_back(a);
            acc_log.push_back(a);
        end
        #1;
        drive_mem();
    endtask

    task automatic do_reset();
        i_rst_n          = 1'b0;
        i_imem_req_ready = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'h0;
        i_instr_ready    = 1'b0;
        mem_en           = 1'b0;
        pend.delete();
        acc_log.delete();
        drive_mem();
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // Watches the decode side until n instructions from first_pc onward have been presented.
    task automatic expect_stream(input string tag, input logic [31:0] first_pc, input int n);
        logic [31:0] pc;
        int          got;
        pc  = first_pc;
        got = 0;
        for (int c = 0; c < 40 && got < n; c++) begin
            if (o_instr_valid) begin
                check({tag, "_pc"}, o_pc, pc);
                check({tag, "_instr"}, o_instruction, mem_word(pc));
                pc += 32'd4;
                got++;
            end
            if (got < n) tick();
        end
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_req_valid", o_imem_req_valid, 0);
        check("rst_instr_valid", o_instr_valid, 0);
        check("rst_instruction", o_instruction, 32'h0000_0013);
        check("rst_pc", o_pc, 0);
        check("rst_addr", o_imem_addr, 0);

        // 1: streaming with ready memory and decode
        do_reset();
        i_imem_req_ready = 1'b1;
        i_instr_ready    = 1'b1;
        mem_en           = 1'b1;
        tick();
        check("t1_req_valid", o_imem_req_valid, 1);
        check("t1_req_addr", o_imem_addr, 32'h0);
        tick();
        check("t1_not_yet_valid", o_instr_valid, 0);
        tick();
        check("t1_first_valid", o_instr_valid, 1);
        expect_stream("t1", 32'h0, 3);

        // 2: decode stall caps outstanding work at two requests
        do_reset();
        i_imem_req_ready = 1'b1;
        mem_en           = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("t2_acc_count", acc_log.size(), 2);
        check("t2_acc0", acc_log[0], 32'h0);
        check("t2_acc1", acc_log[1], 32'h4);
        check("t2_req_stalled", o_imem_req_valid, 0);
        check("t2_head_pc", o_pc, 32'h0);
        i_instr_ready = 1'b1;
        tick();
        check("t2_req_after_pop", o_imem_req_valid, 1);
        check("t2_addr_after_pop", o_imem_addr, 32'h8);
        check("t2_next_pc", o_pc, 32'h4);

        // 3: redirect with two requests outstanding, unaligned target
        do_reset();
        i_imem_req_ready = 1'b1;
        i_instr_ready    = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t3_outstanding", acc_log.size(), 2);
        check("t3_req_blocked", o_imem_req_valid, 0);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0102;
        tick();
        i_redirect_valid = 1'b0;
        mem_en           = 1'b1;
        drive_mem();
        check("t3_flush_req0", o_imem_req_valid, 0);
        check("t3_flush_valid", o_instr_valid, 0);
        tick();
        check("t3_flush_req1", o_imem_req_valid, 0);
        tick();
        check("t3_resume_req", o_imem_req_valid, 1);
        check("t3_resume_addr", o_imem_addr, 32'h0000_0100);
        expect_stream("t3", 32'h0000_0100, 1);

        // 4: redirect with a full buffer and nothing outstanding, target near wrap
        do_reset();
        i_imem_req_ready = 1'b1;
        mem_en           = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t4_full_valid", o_instr_valid, 1);
        check("t4_full_pc", o_pc, 32'h0);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'hFFFF_FFFE;
        tick();
        i_redirect_valid = 1'b0;
        check("t4_emptied", o_instr_valid, 0);
        check("t4_req_valid", o_imem_req_valid, 1);
        check("t4_req_addr", o_imem_addr, 32'hFFFF_FFFC);
        i_instr_ready = 1'b1;
        expect_stream("t4", 32'hFFFF_FFFC, 2);

        // 5: redirect coinciding with a response, a request accept and a pop
        do_reset();
        i_imem_req_ready = 1'b1;
        i_instr_ready    = 1'b1;
        mem_en           = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t5_pre_pc", o_pc, 32'h4);
        check("t5_pre_req", o_imem_req_valid, 1);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0300;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        i_redirect_valid = 1'b0;
        check("t5_flush_valid", o_instr_valid, 0);
        check("t5_flush_req", o_imem_req_valid, 0);
        tick();
        check("t5_resume_req", o_imem_req_valid, 1);
        check("t5_resume_addr", o_imem_addr, 32'h0000_0300);
        expect_stream("t5", 32'h0000_0300, 2);

        // 6: asynchronous reset while flushing
        do_reset();
        i_imem_req_ready = 1'b1;
        i_instr_ready    = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0102;
        tick();
        i_redirect_valid = 1'b0;
        check("t6_flush_addr", o_imem_addr, 32'h0000_0100);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t6_async_req", o_imem_req_valid, 0);
        check("t6_async_valid", o_instr_valid, 0);
        check("t6_async_addr", o_imem_addr, 32'h0);
        pend.delete();
        mem_en = 1'b1;
        drive_mem();
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check("t6_restart_req", o_imem_req_valid, 1);
        check("t6_restart_addr", o_imem_addr, 32'h0);
        expect_stream("t6", 32'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
